control_unit: RTL

- Multicycle FSM that sequences the accumulator datapath.
- Fetches 16-bit instructions from a synchronous program memory, holds them in an instruction register (IR) and maintains the PC.
- Drives every datapath control input: operand, alu_op, sel_A, sel_B, acc_wr, acc_reset, status_wr, status_reset.
- Drives the data-memory write strobe; consumes the datapath's Z/N flags for branches.

---
 rtl/control_unit.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/control_unit.sv
// -----------------------------------------------------------------------------
// control_unit
// Multicycle sequencer for the accumulator datapath. It fetches 16-bit
// instructions from a synchronous program memory, holds them in the IR,
// maintains the PC, and decodes each instruction into the datapath's
// control inputs.
//
// Ports
//   clock_in          rising-edge clock
//   reset_n_in        asynchronous active-low reset
//   enable_in         FSM advances only while high (ignored in HALT)
//   instruction_in    program memory read data, one cycle after the address
//   flag_Z_in/N_in    datapath status flags, used by conditional branches
//   prog_address_out  program memory address (PC)
//   operand_out       IR operand field
//   alu_op_out        0 add, 1 subtract
//   sel_A_out         ACC source: 00 ALU, 01 extended operand, 10 data memory
//   sel_B_out         ALU B operand: 0 data memory, 1 extended operand
//   acc_wr_out        accumulator write enable
//   acc_reset_out     accumulator synchronous clear
//   status_wr_out     status register write enable
//   status_reset_out  status register synchronous clear
//   data_mem_wr_out   data memory write strobe (STO)
//   halted_out        high in HALT
// -----------------------------------------------------------------------------
module control_unit #(
  parameter int OPERAND_WIDTH = 11,
  parameter int DATA_WIDTH    = 16,
  parameter int OPCODE_WIDTH  = 5
) (
  input  logic                     clock_in,
  input  logic                     reset_n_in,
  input  logic                     enable_in,
  input  logic [DATA_WIDTH-1:0]    instruction_in,
  input  logic                     flag_Z_in,
  input  logic                     flag_N_in,
  output logic [OPERAND_WIDTH-1:0] prog_address_out,
  output logic [OPERAND_WIDTH-1:0] operand_out,
  output logic                     alu_op_out,
  output logic [1:0]               sel_A_out,
  output logic                     sel_B_out,
  output logic                     acc_wr_out,
  output logic                     acc_reset_out,
  output logic                     status_wr_out,
  output logic                     status_reset_out,
  output logic                     data_mem_wr_out,
  output logic                     halted_out
);

  typedef enum logic [2:0] {
    ST_INIT    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_LOAD    = 3'd3,
    ST_EXECUTE = 3'd4,
    ST_HALT    = 3'd5
  } state_t;

  localparam logic [OPCODE_WIDTH-1:0] OP_HLT  = OPCODE_WIDTH'(5'd0);
  localparam logic [OPCODE_WIDTH-1:0] OP_STO  = OPCODE_WIDTH'(5'd1);
  localparam logic [OPCODE_WIDTH-1:0] OP_LD   = OPCODE_WIDTH'(5'd2);
  localparam logic [OPCODE_WIDTH-1:0] OP_LDI  = OPCODE_WIDTH'(5'd3);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADD  = OPCODE_WIDTH'(5'd4);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADDI = OPCODE_WIDTH'(5'd5);
  localparam logic [OPCODE_WIDTH-1:0] OP_SUB  = OPCODE_WIDTH'(5'd6);
  localparam logic [OPCODE_WIDTH-1:0] OP_SUBI = OPCODE_WIDTH'(5'd7);
  localparam logic [OPCODE_WIDTH-1:0] OP_BEQ  = OPCODE_WIDTH'(5'd8);
  localparam logic [OPCODE_WIDTH-1:0] OP_BNE  = OPCODE_WIDTH'(5'd9);
  localparam logic [OPCODE_WIDTH-1:0] OP_BGT  = OPCODE_WIDTH'(5'd10);
  localparam logic [OPCODE_WIDTH-1:0] OP_BGE  = OPCODE_WIDTH'(5'd11);
  localparam logic [OPCODE_WIDTH-1:0] OP_BLT  = OPCODE_WIDTH'(5'd12);
  localparam logic [OPCODE_WIDTH-1:0] OP_BLE  = OPCODE_WIDTH'(5'd13);
  localparam logic [OPCODE_WIDTH-1:0] OP_JMP  = OPCODE_WIDTH'(5'd14);

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [OPERAND_WIDTH-1:0] r_pc;
  logic [OPERAND_WIDTH-1:0] w_pc_nxt;
  logic [DATA_WIDTH-1:0]    r_ir;
  logic [DATA_WIDTH-1:0]    w_ir_nxt;

  logic [OPCODE_WIDTH-1:0]  w_ir_op;
  logic [OPCODE_WIDTH-1:0]  w_fetch_op;
  logic [OPERAND_WIDTH-1:0] w_ir_operand;
  logic                     w_taken;

  // Raw (ungated) control strobes produced by the decoder
  logic                     w_acc_wr;
  logic                     w_status_wr;
  logic                     w_mem_wr;
  logic                     w_clr;
  logic                     w_alu_op;
  logic [1:0]               w_sel_a;
  logic                     w_sel_b;
  logic                     w_halted;

  assign w_ir_op      = r_ir[DATA_WIDTH-1 -: OPCODE_WIDTH];
  assign w_ir_operand = r_ir[OPERAND_WIDTH-1:0];
  assign w_fetch_op   = instruction_in[DATA_WIDTH-1 -: OPCODE_WIDTH];

  // State, PC and IR registers
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      r_state <= ST_INIT;
      r_pc    <= {OPERAND_WIDTH{1'b0}};
      r_ir    <= {DATA_WIDTH{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_ir    <= w_ir_nxt;
    end
  end

  // Branch condition evaluation on the IR opcode and current flags
  always_comb begin
    w_taken = 1'b0;
    case (w_ir_op)
      OP_BEQ:  w_taken = flag_Z_in;
      OP_BNE:  w_taken = !flag_Z_in;
      OP_BGT:  w_taken = !flag_Z_in && !flag_N_in;
      OP_BGE:  w_taken = !flag_N_in;
      OP_BLT:  w_taken = flag_N_in;
      OP_BLE:  w_taken = flag_N_in || flag_Z_in;
      OP_JMP:  w_taken = 1'b1;
      default: w_taken = 1'b0;
    endcase
  end

  // Next-state, PC/IR update and raw control decode
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_ir_nxt    = r_ir;
    w_acc_wr    = 1'b0;
    w_status_wr = 1'b0;
    w_mem_wr    = 1'b0;
    w_clr       = 1'b0;
    w_alu_op    = 1'b0;
    w_sel_a     = 2'b00;
    w_sel_b     = 1'b0;
    w_halted    = 1'b0;

    case (r_state)
      ST_INIT: begin
        w_clr = 1'b1;
        if (enable_in) begin
          w_state_nxt = ST_FETCH;
        end else begin
          w_state_nxt = ST_INIT;
        end
      end

      ST_FETCH: begin
        if (enable_in) begin
          w_state_nxt = ST_DECODE;
        end else begin
          w_state_nxt = ST_FETCH;
        end
      end

      ST_DECODE: begin
        if (enable_in) begin
          w_ir_nxt = instruction_in;
          w_pc_nxt = r_pc + OPERAND_WIDTH'(1'b1);  // natural wrap at the top
          if ((w_fetch_op == OP_LD) || (w_fetch_op == OP_ADD) || (w_fetch_op == OP_SUB)) begin
            w_state_nxt = ST_LOAD;
          end else begin
            w_state_nxt = ST_EXECUTE;
          end
        end else begin
          w_state_nxt = ST_DECODE;
        end
      end

      ST_LOAD: begin
        // operand_out already drives the data memory address; just wait
        if (enable_in) begin
          w_state_nxt = ST_EXECUTE;
        end else begin
          w_state_nxt = ST_LOAD;
        end
      end

      ST_EXECUTE: begin
        case (w_ir_op)
          OP_STO:  w_mem_wr = 1'b1;
          OP_LD: begin
            w_sel_a  = 2'b10;
            w_acc_wr = 1'b1;
          end
          OP_LDI: begin
            w_sel_a  = 2'b01;
            w_acc_wr = 1'b1;
          end
          OP_ADD, OP_ADDI, OP_SUB, OP_SUBI: begin
            w_alu_op    = (w_ir_op == OP_SUB) || (w_ir_op == OP_SUBI);
            w_sel_b     = (w_ir_op == OP_ADDI) || (w_ir_op == OP_SUBI);
            w_sel_a     = 2'b00;
            w_acc_wr    = 1'b1;
            w_status_wr = 1'b1;
          end
          default: w_acc_wr = 1'b0;
        endcase

        if (enable_in) begin
          // A taken branch overrides the increment applied in DECODE
          if (w_taken) begin
            w_pc_nxt = w_ir_operand;
          end else begin
            w_pc_nxt = r_pc;
          end
          if (w_ir_op == OP_HLT) begin
            w_state_nxt = ST_HALT;
          end else begin
            w_state_nxt = ST_FETCH;
          end
        end else begin
          w_state_nxt = ST_EXECUTE;
        end
      end

      ST_HALT: begin
        w_halted    = 1'b1;
        w_state_nxt = ST_HALT;
      end

      default: w_state_nxt = ST_INIT;
    endcase
  end

  // Strobes are suppressed while paused; the clears stay visible while the
  // reset pin itself is held low so the datapath is cleared alongside.
  assign acc_wr_out       = w_acc_wr && enable_in;
  assign status_wr_out    = w_status_wr && enable_in;
  assign data_mem_wr_out  = w_mem_wr && enable_in;
  assign acc_reset_out    = w_clr && (enable_in || !reset_n_in);
  assign status_reset_out = w_clr && (enable_in || !reset_n_in);
  assign alu_op_out       = w_alu_op;
  assign sel_A_out        = w_sel_a;
  assign sel_B_out        = w_sel_b;
  assign halted_out       = w_halted;
  assign prog_address_out = r_pc;
  assign operand_out      = w_ir_operand;

endmodule
